// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding and
// default geometry.
package pc_sequencer_pkg;

    localparam int DEFAULT_WIDTH        = 8;
    localparam int DEFAULT_RESET_VECTOR = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_FETCH   = 2'b01,
        ST_STALLED = 2'b10,
        ST_HALT    = 2'b11
    } pc_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/fetch-address bundle between the pipeline and the PC sequencer.
// The LINK/LINK_PC pair exists only when PC_LINK_EN is defined.
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             run;
    logic             stall;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
    logic             halt_req;
    logic [WIDTH-1:0] pc;
    logic             pc_valid;
    logic             halted;
`ifdef PC_LINK_EN
    logic             link;
    logic [WIDTH-1:0] link_pc;

    modport master (
        output run, stall, br_taken, br_target, halt_req, link,
        input  pc, pc_valid, halted, link_pc
    );
    modport slave (
        input  run, stall, br_taken, br_target, halt_req, link,
        output pc, pc_valid, halted, link_pc
    );
`else
    modport master (
        output run, stall, br_taken, br_target, halt_req,
        input  pc, pc_valid, halted
    );
    modport slave (
        input  run, stall, br_taken, br_target, halt_req,
        output pc, pc_valid, halted
    );
`endif
endinterface

// File: rtl/pc_sequencer_pc_reg.sv
// WIDTH-bit load-enabled register built from per-bit D flip-flop cells,
// synchronous active-low reset to RESET_VALUE.
module pc_reg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             r,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic bit_reg;

            always_ff @(posedge clk) begin
                if (!r) begin
                    bit_reg <= RESET_VALUE[gi];
                end else if (load) begin
                    bit_reg <= d[gi];
                end
            end

            assign q[gi] = bit_reg;
        end
    endgenerate

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage ahead of instruction fetch: advance, redirect, stall
// and halt. Define PC_LINK_EN to add the LINK input and LINK_PC register.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               WIDTH        = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic           clk,
    input  logic           r,
    pc_sequencer_if.slave  bus
);

    pc_state_t        state_reg;
    pc_state_t        state_next;
    logic             pc_load;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_plus_one;
    logic             link_load;

    assign pc_plus_one = pc_q + WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!r) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_load    = 1'b0;
        pc_next    = pc_q;
        link_load  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.run) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Branch outranks stall: the redirected address is fetched next.
                if (bus.halt_req) begin
                    state_next = ST_HALT;
                end else if (bus.br_taken) begin
                    pc_load   = 1'b1;
                    pc_next   = bus.br_target;
`ifdef PC_LINK_EN
                    link_load = bus.link;
`endif
                end else if (bus.stall) begin
                    state_next = ST_STALLED;
                end else begin
                    pc_load = 1'b1;
                    pc_next = pc_plus_one;
                end
            end
            ST_STALLED: begin
                if (bus.halt_req) begin
                    state_next = ST_HALT;
                end else if (bus.br_taken) begin
                    pc_load    = 1'b1;
                    pc_next    = bus.br_target;
                    state_next = ST_FETCH;
                end else if (!bus.stall) begin
                    state_next = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (bus.run) begin
                    pc_load    = 1'b1;
                    pc_next    = RESET_VECTOR;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    pc_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VECTOR)
    ) u_pc_reg (
        .clk  (clk),
        .r    (r),
        .load (pc_load),
        .d    (pc_next),
        .q    (pc_q)
    );

    assign bus.pc       = pc_q;
    assign bus.pc_valid = (state_reg == ST_FETCH);
    assign bus.halted   = (state_reg == ST_HALT);

`ifdef PC_LINK_EN
    logic [WIDTH-1:0] link_q;

    pc_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE ('0)
    ) u_link_reg (
        .clk  (clk),
        .r    (r),
        .load (link_load),
        .d    (pc_plus_one),
        .q    (link_q)
    );

    assign bus.link_pc = link_q;
`else
    logic unused_link;
    assign unused_link = link_load;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios followed by random
// stimulus, checked against a behavioural model of the sequencing rules.
module tb_pc_sequencer;

    localparam int W   = 8;
    localparam int MOD = 1 << W;
    localparam int RV  = 0;

    localparam int M_IDLE    = 0;
    localparam int M_FETCH   = 1;
    localparam int M_STALLED = 2;
    localparam int M_HALT    = 3;

    logic clk = 1'b0;
    logic r   = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.WIDTH(W)) bus ();

    pc_sequencer #(
        .WIDTH        (W),
        .RESET_VECTOR (W'(RV))
    ) dut (
        .clk (clk),
        .r   (r),
        .bus (bus)
    );

    typedef struct {
        int pc;
        int valid;
        int halted;
        int link_pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    int m_mode = M_IDLE;
    int m_pc   = RV;
    int m_link = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (txn %0d)", name, act, expv, n_txn);
        end
    endtask

    // Reference: what the outputs must show after the coming rising edge.
    function automatic void model_step(input int rr, input int run, input int stall,
                                       input int br, input int tgt, input int halt,
                                       input int lk);
        if (rr == 0) begin
            m_mode = M_IDLE;
            m_pc   = RV;
            m_link = 0;
        end else if (m_mode == M_IDLE) begin
            if (run != 0) m_mode = M_FETCH;
        end else if (m_mode == M_FETCH) begin
            if (halt != 0) begin
                m_mode = M_HALT;
            end else if (br != 0) begin
`ifdef PC_LINK_EN
                if (lk != 0) m_link = (m_pc + 1) % MOD;
`endif
                m_pc = tgt % MOD;
            end else if (stall != 0) begin
                m_mode = M_STALLED;
            end else begin
                m_pc = (m_pc + 1) % MOD;
            end
        end else if (m_mode == M_STALLED) begin
            if (halt != 0) begin
                m_mode = M_HALT;
            end else if (br != 0) begin
                m_pc   = tgt % MOD;
                m_mode = M_FETCH;
            end else if (stall == 0) begin
                m_mode = M_FETCH;
            end
        end else begin
            if (run != 0) begin
                m_pc   = RV;
                m_mode = M_IDLE;
            end
        end
        if (lk < 0) m_link = 0;
    endfunction

    task automatic step(input int rr, input int run, input int stall, input int br,
                        input int tgt, input int halt, input int lk);
        exp_t e;
        @(negedge clk);
        r             = rr[0];
        bus.run       = run[0];
        bus.stall     = stall[0];
        bus.br_taken  = br[0];
        bus.br_target = W'(tgt);
        bus.halt_req  = halt[0];
`ifdef PC_LINK_EN
        bus.link      = lk[0];
`endif
        model_step(rr, run, stall, br, tgt, halt, lk);
        e.pc      = m_pc;
        e.valid   = (m_mode == M_FETCH) ? 1 : 0;
        e.halted  = (m_mode == M_HALT) ? 1 : 0;
        e.link_pc = m_link;
        exp_q.push_back(e);
    endtask

    task automatic free_run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are registered, so every edge is one transaction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_txn++;
                $display("txn %0d: pc=0x%02h valid=%0b halted=%0b", n_txn, bus.pc,
                         bus.pc_valid, bus.halted);
                chk("pc", int'(bus.pc), e.pc);
                chk("pc_valid", int'(bus.pc_valid), e.valid);
                chk("halted", int'(bus.halted), e.halted);
`ifdef PC_LINK_EN
                chk("link_pc", int'(bus.link_pc), e.link_pc);
`endif
            end
        end
    end

    initial begin : driver
        bus.run       = 1'b0;
        bus.stall     = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_target = '0;
        bus.halt_req  = 1'b0;
`ifdef PC_LINK_EN
        bus.link      = 1'b0;
`endif
        // Reset then start: idle at vector, then 0,1,2,3 valid.
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        free_run(4);
        // Branch with simultaneous stall.
        step(1, 0, 0, 1, 8'h05, 0, 0);
        step(1, 0, 1, 1, 8'h40, 0, 0);
        free_run(1);
        // Stall hold and re-fetch.
        step(1, 0, 0, 1, 8'h07, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        free_run(2);
        // Wrap-around.
        step(1, 0, 0, 1, 8'hFE, 0, 0);
        free_run(3);
        // Halt, ignored branch/stall, restart.
        step(1, 0, 0, 1, 8'h12, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 1, 1, 8'h99, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        free_run(2);
        // Run ignored in FETCH; branch-and-link; reset while stalled.
        step(1, 1, 0, 1, 8'h30, 0, 0);
        step(1, 0, 0, 1, 8'h80, 0, 1);
        step(1, 0, 1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 8'h55, 1, 1);
        step(1, 1, 0, 0, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            int tgt;
            tgt = ($urandom_range(0, 7) == 0) ? $urandom_range(8'hFC, 8'hFF)
                                              : $urandom_range(0, 255);
            step(($urandom_range(0, 63) != 0) ? 1 : 0,
                 ($urandom_range(0, 3) == 0) ? 1 : 0,
                 ($urandom_range(0, 2) == 0) ? 1 : 0,
                 ($urandom_range(0, 4) == 0) ? 1 : 0,
                 tgt,
                 ($urandom_range(0, 15) == 0) ? 1 : 0,
                 int'($urandom_range(0, 1)));
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage of the RISC core; sits directly upstream of instruction fetch.
- Its state register bank is the consumer of the team's D flip-flop cells.
- Holds the current PC, advances it by one per cycle, redirects on taken branches, freezes on stall and parks in a halted state on request.
- Drives PC/PC_VALID to the instruction memory address port.

Parameters:
- WIDTH, 8, PC width in bits (word-addressed).
- RESET_VECTOR, 0, PC value loaded on reset and on restart from HALT.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- R  input  1  reset; synchronous, active-low.
- RUN  input  1  start/restart request; leaves IDLE or HALT.
- STALL  input  1  freeze PC this cycle (hazard from downstream).
- BR_TAKEN  input  1  branch/jump taken; load BR_TARGET.
- BR_TARGET  input  WIDTH  branch destination.
- HALT_REQ  input  1  stop fetching after the current PC.
- PC  output  WIDTH  current fetch address.
- PC_VALID  output  1  PC is a live fetch address this cycle.
- HALTED  output  1  sequencer is in HALT.

Behaviour:
- Reset: CLK and R are the only clock/reset. R low at a rising edge (synchronous, active-low) forces state IDLE, PC=RESET_VECTOR, PC_VALID=0, HALTED=0. Reset has priority over every other input, including mid-branch or mid-stall.
- States (2-bit encoding): IDLE=00, FETCH=01, STALLED=10, HALT=11.
- IDLE:
  - PC holds RESET_VECTOR, PC_VALID=0.
  - RUN=1 -> FETCH next cycle, PC unchanged.
  - First valid fetch is therefore at RESET_VECTOR, one cycle after RUN.
- FETCH: PC_VALID=1. Input priority, highest first:
  - HALT_REQ=1 -> HALT, PC holds.
  - BR_TAKEN=1 -> PC<=BR_TARGET, stay FETCH. A branch overrides STALL.
  - STALL=1 -> STALLED, PC holds.
  - Otherwise PC<=PC+1.
- STALLED: PC_VALID=0, PC holds.
  - HALT_REQ=1 -> HALT.
  - BR_TAKEN=1 -> PC<=BR_TARGET, then FETCH.
  - STALL=0 -> FETCH, PC unchanged (the stalled address is re-fetched).
  - STALL=1 -> stay.
- HALT: PC_VALID=0, HALTED=1, PC holds.
  - RUN=1 -> PC<=RESET_VECTOR, then IDLE.
  - BR_TAKEN and STALL are ignored.
- Increment: modulo 2^WIDTH; PC=all-ones wraps to 0 with no flag.
- Latency:
  - All outputs are registered or decoded from state only, so there is no combinational input-to-output path.
  - A redirect becomes visible on PC one cycle after BR_TAKEN is sampled.
- RUN while in FETCH or STALLED: ignored.

Optional Feature:
- Macro: PC_LINK_EN.
- When defined:
  - Adds input LINK (1) and output LINK_PC (WIDTH).
  - On BR_TAKEN=1 with LINK=1 in FETCH, LINK_PC<=PC+1 (return address, modulo 2^WIDTH), in the same cycle as the redirect.
  - LINK_PC resets to 0.
  - LINK is ignored in all other states, and when BR_TAKEN=0.
- When undefined: no LINK/LINK_PC ports and no link register; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE/FETCH/STALLED/HALT);
  - default WIDTH;
  - default RESET_VECTOR.
- One natural sub-module, pc_reg: WIDTH-bit register with synchronous active-low reset to a parameter value and a load enable. Instantiated for PC, and for LINK_PC when PC_LINK_EN is defined.
- Next-state logic, incrementer and muxing stay in pc_sequencer.

Test Plan:
- Reset then start: R=0 for 2 cycles, then RUN=1 for 1 cycle -> PC=0 with PC_VALID=0 in IDLE; then PC=0,1,2,3 with PC_VALID=1 on successive cycles.
- Branch with simultaneous stall: in FETCH at PC=5, BR_TAKEN=1, BR_TARGET=0x40, STALL=1 -> next PC=0x40, state FETCH; following cycle PC=0x41.
- Stall hold: at PC=7, STALL=1 for 3 cycles -> PC stays 7, PC_VALID=0 for 3 cycles; STALL=0 -> PC=7 valid, then 8.
- Wrap-around (WIDTH=8): BR_TARGET=0xFE, then free-run -> PC sequence 0xFE, 0xFF, 0x00.
- Halt and restart: HALT_REQ=1 at PC=0x12 -> HALTED=1, PC=0x12 held, BR_TAKEN ignored; RUN=1 -> IDLE with PC=0; RUN=1 again -> fetches resume from 0.
- Mid-operation reset, plus PC_LINK_EN: at PC=0x30, BR_TAKEN=1, LINK=1, BR_TARGET=0x80 -> PC=0x80 and LINK_PC=0x31. Then R=0 while STALLED -> next cycle IDLE, PC=0, LINK_PC=0, PC_VALID=0.
